dsc_mul_nway: RTL
=================

DSC_MUL_NWAY -- requirements
Module: dsc_mul_nway

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per operand.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, operand count (>=2).
REQ-003 SHALL derive OUT_W = NUM_INPUTS*DATA_WIDTH and CW = OUT_W+1 as localparams.
REQ-004 SHALL have port gclk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, run enable; low freezes all state.
REQ-007 SHALL have port start, input, 1, single-cycle operation request.
REQ-008 SHALL have port bin_data_in, input, OUT_W; operand i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port cycle_budget, input, CW; cycle limit, 0 = unlimited.
REQ-010 SHALL have port bin_data_out, output, OUT_W; ones count of the product stream.
REQ-011 SHALL have port busy, output, 1; high in RUN.
REQ-012 SHALL have port op_finished, output, 1; high in DONE.
REQ-013 SHALL have port truncated, output, 1; high if the last op ended on budget.
REQ-014 SHALL have port cycle_count, output, CW; stream cycles consumed by the current/last op.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DONE.
REQ-016 In IDLE or DONE with start=1 and en=1, SHALL capture operands, clear accumulator, cycle_count, truncated and operand counters, then enter RUN; start is ignored in RUN.
REQ-017 If any captured operand is 0, SHALL go directly to DONE with bin_data_out=0 and cycle_count=0.
REQ-018 SHALL keep one DATA_WIDTH counter per operand; stream bit i = (ctr_i < x_i); product bit = AND of all stream bits.
REQ-019 Each RUN cycle with en=1: SHALL add the product bit to the accumulator, increment cycle_count, and increment ctr_0; ctr_i (i>0) SHALL increment only when ctr_0..ctr_(i-1) are all at max (clock-division chain).
REQ-020 SHALL enter DONE on the cycle whose update sets ctr_(NUM_INPUTS-1) equal to x_(NUM_INPUTS-1); cycle_count then equals x_(N-1)*2^((N-1)*DATA_WIDTH) and bin_data_out the exact product.
REQ-021 In DONE, bin_data_out, cycle_count and truncated SHALL hold until the next accepted start.
REQ-022 With en=0, all registers SHALL hold, including in RUN.
REQ-023 The accumulator SHALL never wrap (max product (2^W-1)^N < 2^OUT_W).

Reset
REQ-024 rst=1 SHALL asynchronously force IDLE and clear all counters, accumulator and captured operands.
REQ-025 Reset values: bin_data_out=0, busy=0, op_finished=0, truncated=0, cycle_count=0.
REQ-026 rst asserted mid-RUN SHALL abort the operation with no DONE; the first start after release begins a fresh op.

Configuration
REQ-027 Macro DSC_CYCLE_BUDGET_EN SHALL gate budget truncation.
REQ-028 With DSC_CYCLE_BUDGET_EN defined: when cycle_budget!=0 and cycle_count reaches cycle_budget before REQ-020 fires, SHALL enter DONE with truncated=1 and the partial count; simultaneous natural finish SHALL report truncated=0.
REQ-029 Without DSC_CYCLE_BUDGET_EN: cycle_budget SHALL be ignored, truncated SHALL stay 0, every op runs to REQ-020.

Verification
REQ-030 W=8,N=2, x=(200,3), budget=0 -> bin_data_out=600, cycle_count=768, truncated=0, op_finished high.
REQ-031 W=8,N=2, x=(255,255) -> bin_data_out=65025, cycle_count=65280.
REQ-032 W=4,N=3, x=(5,0,7) -> DONE with bin_data_out=0, cycle_count=0, one cycle after start.
REQ-033 DSC_CYCLE_BUDGET_EN, W=8,N=2, x=(200,3), budget=300 -> bin_data_out=244, cycle_count=300, truncated=1; without macro -> 600/768/0.
REQ-034 x=(200,3), en low 50 cycles mid-RUN -> identical result and cycle_count as REQ-030; start pulses during RUN ignored.
REQ-035 rst pulsed at cycle 100 of RUN -> all outputs 0, state IDLE; subsequent start with x=(10,2) -> 20, cycle_count 512.

Source files
------------

// File: rtl/dsc_mul_nway.sv
// N-way unary (stream) multiplier: product = ones count of the AND of per-operand comparator streams.
// Optional cycle-budget truncation is compiled in with `define DSC_CYCLE_BUDGET_EN.

module dsc_mul_nway_lane #(
  parameter int W = 8
) (
  input  logic         gclk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] x_i,
  input  logic         step_i,
  output logic         bit_o,
  output logic         max_o,
  output logic         hit_o
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] x_q, ctr_q;

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      ctr_q <= '0;
    end else if (ld_i) begin
      x_q   <= x_i;
      ctr_q <= '0;
    end else if (step_i) begin
      ctr_q <= ctr_q + ONE;
    end
  end

  assign bit_o = (ctr_q < x_q);
  assign max_o = &ctr_q;
  // True when this step's increment lands the counter on its operand.
  assign hit_o = ((ctr_q + ONE) == x_q);
endmodule

module dsc_mul_nway #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2
) (
  input  logic                                gclk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                start,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]    bin_data_in,
  input  logic [NUM_INPUTS*DATA_WIDTH:0]      cycle_budget,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]    bin_data_out,
  output logic                                busy,
  output logic                                op_finished,
  output logic                                truncated,
  output logic [NUM_INPUTS*DATA_WIDTH:0]      cycle_count
);
  localparam int OUT_W = NUM_INPUTS*DATA_WIDTH;
  localparam int CW    = OUT_W+1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic [OUT_W-1:0]   acc_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               trunc_q;

  logic [NUM_INPUTS-1:0] sbit, smax, shit, carry;
  logic                  ld, any_zero, pbit, fin, budget_hit;

  assign ld       = en & start & (state_q != S_RUN);
  assign carry[0] = en & (state_q == S_RUN);
  assign pbit     = &sbit;
  assign fin      = carry[NUM_INPUTS-1] & shit[NUM_INPUTS-1];
  assign cnt_d    = cnt_q + CW'(1);

  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (bin_data_in[i*DATA_WIDTH +: DATA_WIDTH] == '0) any_zero = 1'b1;
  end

  // Clock-division chain: lane g steps only when all lower lanes wrap.
  genvar g;
  generate
    for (g = 0; g < NUM_INPUTS; g++) begin : g_lane
      dsc_mul_nway_lane #(.W(DATA_WIDTH)) u_lane (
        .gclk   (gclk),
        .rst    (rst),
        .ld_i   (ld),
        .x_i    (bin_data_in[g*DATA_WIDTH +: DATA_WIDTH]),
        .step_i (carry[g]),
        .bit_o  (sbit[g]),
        .max_o  (smax[g]),
        .hit_o  (shit[g])
      );
      if (g < NUM_INPUTS-1) begin : g_chain
        assign carry[g+1] = carry[g] & smax[g];
      end
    end
  endgenerate

`ifdef DSC_CYCLE_BUDGET_EN
  assign budget_hit = (cycle_budget != '0) && (cnt_d == cycle_budget);
`else
  logic unused_budget;
  assign unused_budget = ^cycle_budget;
  assign budget_hit    = 1'b0;
`endif

  logic unused_lane;
  assign unused_lane = ^{shit[NUM_INPUTS-2:0], smax[NUM_INPUTS-1]};

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          acc_q   <= '0;
          cnt_q   <= '0;
          trunc_q <= 1'b0;
          state_q <= any_zero ? S_DONE : S_RUN;
        end
        S_RUN: begin
          acc_q <= acc_q + OUT_W'(pbit);
          cnt_q <= cnt_d;
          // Natural finish wins over a budget hit on the same cycle.
          if (fin) begin
            state_q <= S_DONE;
          end else if (budget_hit) begin
            state_q <= S_DONE;
            trunc_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bin_data_out = acc_q;
  assign cycle_count  = cnt_q;
  assign truncated    = trunc_q;
  assign busy         = (state_q == S_RUN);
  assign op_finished  = (state_q == S_DONE);
endmodule
